// File: rtl/csel_pkg.sv
// csel_pkg: shared definitions for the pipelined carry-select adder.
//   csel_params_ok : elaboration-time check of the WIDTH/BLK pairing.
//   csel_ref       : bit-serial reference adder/subtractor (up to 64 bits),
//                    returns the modulo-2^width sum, carry-out and signed
//                    overflow for the verification model.
package csel_pkg;

    localparam int unsigned CSEL_MAX_W = 64;

    typedef struct packed {
        logic [CSEL_MAX_W-1:0] sum;
        logic                  cout;
        logic                  ovf;
    } csel_res_t;

    function automatic bit csel_params_ok(input int unsigned width, input int unsigned blk);
        return (blk >= 2) && (width >= blk) && ((width % blk) == 0);
    endfunction

    function automatic csel_res_t csel_ref(input logic [CSEL_MAX_W-1:0] a,
                                           input logic [CSEL_MAX_W-1:0] b,
                                           input logic cin,
                                           input logic sub,
                                           input int unsigned width);
        csel_res_t r;
        logic      c;
        logic      cm;
        logic      bb;
        r  = '0;
        c  = sub ? 1'b1 : cin;
        cm = 1'b0;
        for (int unsigned i = 0; i < width; i++) begin
            bb         = sub ? ~b[i] : b[i];
            r.sum[i]   = a[i] ^ bb ^ c;
            if (i == width - 1) cm = c;
            c          = (a[i] & bb) | (c & (a[i] ^ bb));
        end
        r.cout = c;
        r.ovf  = cm ^ c;
        return r;
    endfunction

endpackage

// File: rtl/csel_block.sv
// csel_block: combinational BLK-bit carry-select slice.
//   a, b  : operand slices (b already inverted for subtraction)
//   ci    : carry into the slice, selects between the two precomputed sums
//   s     : selected sum slice
//   co    : carry out of the slice
//   c_msb : carry into the slice MSB (used for signed overflow)
module csel_block #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [BLK-1:0] s0, s1;
    logic [BLK:0]   k0, k1;

    // Two ripple chains, one assuming carry-in 0 and one assuming carry-in 1.
    always_comb begin
        s0    = '0;
        s1    = '0;
        k0    = '0;
        k1    = '0;
        k1[0] = 1'b1;
        for (int unsigned i = 0; i < BLK; i++) begin
            s0[i]   = a[i] ^ b[i] ^ k0[i];
            s1[i]   = a[i] ^ b[i] ^ k1[i];
            k0[i+1] = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
            k1[i+1] = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
        end
    end

    assign s     = ci ? s1 : s0;
    assign co    = ci ? k1[BLK] : k0[BLK];
    assign c_msb = ci ? k1[BLK-1] : k0[BLK-1];

endmodule

// File: rtl/csel_pipe_adder.sv
// csel_pipe_adder: pipelined carry-select adder/subtractor with valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, cin, sub      : operands; sub=1 gives a-b, sub=0 gives a+b+cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry-out (no-borrow for sub), signed overflow
// One BLK-bit slice is resolved per stage; latency is WIDTH/BLK cycles after
// the accepting edge. The whole pipe advances together or holds together.
module csel_pipe_adder
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = WIDTH / BLK;

    if (!csel_params_ok(WIDTH, BLK)) begin : g_param_check
        $error("csel_pipe_adder: WIDTH must be a multiple of BLK and BLK must be >= 2");
    end

    // Operand capture register (effective operand and carry already formed).
    logic             iv_q, ic_q;
    logic [WIDTH-1:0] ia_q, ib_q;

    // State after stage k: valid, carry out, skewed operands, resolved sum.
    logic             v_q [NSTG];
    logic             c_q [NSTG];
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             ovf_q;

    // Stage inputs and per-stage results.
    logic             v_d   [NSTG];
    logic             c_d   [NSTG];
    logic [WIDTH-1:0] a_d   [NSTG];
    logic [WIDTH-1:0] b_d   [NSTG];
    logic [WIDTH-1:0] s_d   [NSTG];
    logic [WIDTH-1:0] s_n   [NSTG];
    logic [BLK-1:0]   blk_s [NSTG];
    logic             c_n   [NSTG];
    logic             msb_n [NSTG];
    logic             adv;

    assign adv      = ~v_q[NSTG-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        v_d[0] = iv_q;
        c_d[0] = ic_q;
        a_d[0] = ia_q;
        b_d[0] = ib_q;
        s_d[0] = '0;
        for (int unsigned k = 1; k < NSTG; k++) begin
            v_d[k] = v_q[k-1];
            c_d[k] = c_q[k-1];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        csel_block #(.BLK(BLK)) u_blk (
            .a     (a_d[k][k*BLK +: BLK]),
            .b     (b_d[k][k*BLK +: BLK]),
            .ci    (c_d[k]),
            .s     (blk_s[k]),
            .co    (c_n[k]),
            .c_msb (msb_n[k])
        );
    end

    // Lower slices pass through; this stage's slice is inserted.
    always_comb begin
        for (int unsigned k = 0; k < NSTG; k++) begin
            s_n[k]                = s_d[k];
            s_n[k][k*BLK +: BLK]  = blk_s[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q  <= 1'b0;
            ic_q  <= 1'b0;
            ia_q  <= '0;
            ib_q  <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < NSTG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            iv_q  <= in_valid;
            ic_q  <= sub | cin;
            ia_q  <= a;
            ib_q  <= sub ? ~b : b;
            ovf_q <= msb_n[NSTG-1] ^ c_n[NSTG-1];
            for (int unsigned k = 0; k < NSTG; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_n[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_n[k];
            end
        end
    end

    assign out_valid = v_q[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_pipe_adder.sv
module tb_csel_pipe_adder;
    import csel_pkg::*;

    localparam int unsigned W   = 16;
    localparam int unsigned B   = 4;
    localparam int unsigned LAT = W / B;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    csel_pipe_adder #(.WIDTH(W), .BLK(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        string       name;
    } vec_t;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    vec_t      vecs [10];
    exp_t      q [$];
    exp_t      e_m;
    csel_res_t r_m;
    bit        sb_on = 1'b0;
    int        total = 0;
    int        bad   = 0;
    int        n_in  = 0;
    int        n_out = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // One clock cycle: scoreboard sampling at the falling edge, then return
    // 1 time unit after the rising edge, ready for new stimulus.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
        end else if (sb_on) begin
            if (in_valid && in_ready) begin
                r_m = csel_ref({48'b0, a}, {48'b0, b}, cin, sub, W);
                q.push_back({r_m.sum[15:0], r_m.cout, r_m.ovf});
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got sum=%h cout=%b ovf=%b with nothing expected", sum, cout, ovf);
                end else begin
                    e_m = q.pop_front();
                    if ({sum, cout, ovf} !== e_m) begin
                        bad++;
                        $display("FAIL sb_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e_m.s, e_m.c, e_m.o);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base_out;
        int          base_in;
        int          cnt;
        int          cyc;
        int          sent;
        logic [17:0] held;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap"};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, "add_wrap_cin"};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_plain"};
        vecs[6] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal"};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_neg_ovf"};
        vecs[8] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, "add_chain"};
        vecs[9] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_zero"};

        // Reset with random inputs
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        a         = 16'($urandom);
        b         = 16'($urandom);
        cin       = 1'($urandom);
        sub       = 1'($urandom);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'h0000);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed table, one operation at a time
        for (int i = 0; i < 10; i++) begin
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            sub      = vecs[i].sub;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (LAT - 1) tick();
            chk({vecs[i].name, "_early"}, 32'(out_valid), 32'd0);
            tick();
            chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].es));
            chk({vecs[i].name, "_cout"}, 32'(cout), 32'(vecs[i].ec));
            chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].eo));
            tick();
        end

        // Backpressure: 8 back-to-back ops, out_ready low on cycles 6..8
        sb_on    = 1'b1;
        base_out = n_out;
        sent     = 0;
        held     = '0;
        cyc      = 0;
        while ((n_out - base_out) < 8 && cyc < 40) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (sent < 8);
            a         = 16'h1111 * 16'(sent + 1);
            b         = 16'hF00F ^ 16'(sent << 4);
            cin       = 1'(sent >> 1);
            sub       = 1'(sent);
            #1;
            chk("bp_in_ready", 32'(in_ready), (cyc >= 6 && cyc <= 8) ? 32'd0 : 32'd1);
            if (cyc == 6) held = {sum, cout, ovf};
            if (cyc == 7 || cyc == 8) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_data", 32'({sum, cout, ovf}), 32'(held));
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(n_out - base_out), 32'd8);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);
        repeat (2) tick();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h0101 * 16'(i + 3);
            b        = 16'h2222;
            cin      = 1'b1;
            sub      = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'h0000);
        tick();
        rst_n = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("midrst_no_output", 32'(cnt), 32'd0);
        chk("midrst_queue_empty", 32'(q.size()), 32'd0);

        // Random traffic against the reference model
        base_in = n_in;
        cyc     = 0;
        while ((n_in - base_in) < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc       = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("rand_accepted", 32'(n_in - base_in), 32'd10000);
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csel_pipe_adder.md
# csel_pipe_adder

Parametrised, pipelined carry-select adder/subtractor. The operand width is split into `WIDTH/BLK` carry-select blocks, with one block resolved per pipeline stage. Each block precomputes sum/carry for carry-in 0 and 1, and the registered carry from the previous stage selects between them. It replaces the single-cycle 4-bit carry-select adder in datapaths that need wide operands, add/sub mode and valid/ready flow control at high clock rates.

## Interface
- `WIDTH`, 32: operand width; must be a multiple of `BLK`.
- `BLK`, 8: block width, ≥ 2.
- `NSTG` (localparam) = `WIDTH/BLK`: number of pipeline stages and latency.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand transfer request.
- `in_ready`  out  1  block can accept an operand set this cycle.
- `a`, `b`  in  `WIDTH`  operands (two's complement or unsigned).
- `cin`  in  1  carry-in; used only when `sub`=0.
- `sub`  in  1  1 = compute `a - b`, 0 = compute `a + b + cin`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  `WIDTH`  result.
- `cout`  out  1  carry-out; for subtraction 1 = no borrow.
- `ovf`  out  1  signed overflow.

## Operation
- Input transfer happens when `in_valid & in_ready`. Output transfer happens when `out_valid & out_ready`.
- Effective operand is `b' = sub ? ~b : b`. Effective carry-in is `c0 = sub ? 1 : cin`.
- Stage k (k = 0..NSTG-1) resolves bits `[k*BLK +: BLK]`:
  - It computes both `BLK`-bit sums and carries (carry-in 0 and 1).
  - It selects one using the carry registered by stage k-1 (`c0` for stage 0).
  - It registers the selected sum slice and the carry-out.
- Unresolved higher operand slices and already-resolved lower sum slices travel in the stage registers (skew/deskew). Nothing is recomputed later.
- The final stage also captures the carry into the MSB (`c_msb`). Then `ovf = c_msb ^ cout`.
- Each stage holds a valid bit. Global advance is `adv = ~out_valid | out_ready`, and `in_ready = adv`.
  - When `adv`=1, every stage loads from its predecessor. Stage 0 loads the input and its valid = `in_valid`.
  - When `adv`=0, all stages hold.
- Bubbles are allowed and propagate. No reordering, no drop, no duplication.
- Arithmetic is modulo 2^WIDTH. Carry/overflow come from the full `WIDTH+1`-bit result.

## Timing
- Latency: an operand set accepted at edge t appears with `out_valid`=1 after edge t+NSTG, assuming no stall.
- Throughput: one operation per cycle while `out_ready`=1.
- Reset (`rst_n`=0, any time, asynchronously):
  - All valid bits clear, so `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - `in_ready`=1 once reset is released.
  - In-flight operations are discarded.
- `in_ready` is combinational from `out_ready` and `out_valid`. No combinational path exists from `a`, `b`, `cin`, `sub` or `in_valid` to any output.
- `sum`, `cout` and `ovf` remain stable while `out_valid & ~out_ready`.
- Simultaneous input accept and output accept is allowed; the pipeline shifts by one.
- Data outputs are don't-care when `out_valid`=0 but are driven from registers (never X after reset).

## Structure
- Shared package `csel_pkg`: parameter checks (`WIDTH % BLK == 0`, `BLK >= 2`) and a `csel_ref` function for the verification model.
- Sub-module `csel_block`: combinational `BLK`-bit carry-select slice.
  - Inputs: `a`, `b`, `ci`.
  - Outputs: `s`, `co`, `c_msb`.
  - Contains the dual ripple adders and the 2:1 selection.
  - `csel_pipe_adder` instantiates NSTG copies via generate, plus per-stage valid and skew registers.

## Test plan
All cases use WIDTH=16, BLK=4, so latency = 4.
- Reset: `rst_n` low for 2 cycles with random inputs → `out_valid`=0, `sum`=0x0000, `cout`=0, `ovf`=0; `in_ready`=1 after release.
- Add wrap: `a`=0xFFFF, `b`=0x0001, `cin`=0 → 4 cycles later `sum`=0x0000, `cout`=1, `ovf`=0. With `cin`=1 → `sum`=0x0001, `cout`=1.
- Subtract: `a`=0x0005, `b`=0x0007, `sub`=1 → `sum`=0xFFFE, `cout`=0, `ovf`=0. Then `a`=0x8000, `b`=0x0001, `sub`=1 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
- Signed overflow add: `a`=0x7FFF, `b`=0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1.
- Backpressure: stream 8 back-to-back adds; drop `out_ready` for 3 cycles mid-stream.
  - `in_ready`=0 for exactly those cycles.
  - All 8 results arrive in order and unchanged while stalled.
- Reset mid-flight plus random: assert `rst_n` with 3 operations in flight → none emerge after release. Then run 10k random add/sub/`cin` operations with random `in_valid`/`out_ready` against the `csel_ref` scoreboard → zero mismatches.
